// File: rtl/irq_ctrl_pkg.sv
// Shared register offsets, VEC field positions and the priority helper for irq_ctrl.
package irq_ctrl_pkg;

    localparam logic [1:0] REG_PEND = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_MODE = 2'd2;
    localparam logic [1:0] REG_VEC  = 2'd3;

    localparam int unsigned VEC_ANY_BIT = 7;
    localparam int unsigned VEC_GIE_BIT = 6;
    localparam int unsigned VEC_IDX_LSB = 0;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (v[i] && !found) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-side register bus of the interrupt controller.
interface irq_ctrl_if;
    logic [1:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;

    modport master (output AD, output DI, output rw, output cs, input DO);
    modport slave  (input AD, input DI, input rw, input cs, output DO);
endinterface

// File: rtl/irq_sync.sv
// Per-source input stage: optional 2-flop synchroniser plus previous-level flop for rise detect.
module irq_sync #(
    parameter bit SYNC = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic s,
    output logic rise
);

    logic prev_q;

    if (SYNC) begin : g_sync
        logic s1_q, s2_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= din;
                s2_q <= s1_q;
            end
        end
        assign s = s2_q;
    end else begin : g_direct
        assign s = din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= s;
        end
    end

    assign rise = s & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped 8-source interrupt controller: PEND/MASK/MODE/VEC registers and a registered intr.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8,
    parameter bit          SYNC    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    irq_ctrl_if.slave          bus,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               intr
);

    logic [NUM_IRQ-1:0] s, rise, pending;
    logic [NUM_IRQ-1:0] mask_q, mode_q, edge_pend_q, edge_pend_d;
    logic [7:0]         pend8, mask8, mode8, active, vec;
    logic [2:0]         idx;
    logic               wr, any, gie_q, intr_q;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
        irq_sync #(.SYNC(SYNC)) u_sync (
            .clk  (clk),
            .rst  (rst),
            .din  (irq_in[i]),
            .s    (s[i]),
            .rise (rise[i])
        );
    end

    assign wr = bus.cs & ~bus.rw;

    // Level bits follow s; gated by rst so reads are 0 during reset even with SYNC=0.
    assign pending = (mode_q & edge_pend_q) | (~mode_q & s & {NUM_IRQ{rst}});

    assign pend8  = 8'(pending);
    assign mask8  = 8'(mask_q);
    assign mode8  = 8'(mode_q);
    assign active = pend8 & mask8;
    assign any    = |active;
    assign idx    = lowest_idx(active);

    // Level-mode bits track s so a switch to edge mode keeps the current value.
    always_comb begin
        edge_pend_d = edge_pend_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!mode_q[i]) begin
                edge_pend_d[i] = s[i];
            end else begin
                if (wr && (bus.AD == REG_PEND) && bus.DI[i]) edge_pend_d[i] = 1'b0;
                if (rise[i]) edge_pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_pend_q <= '0;
            mask_q      <= '0;
            mode_q      <= '0;
            gie_q       <= 1'b0;
            intr_q      <= 1'b0;
        end else begin
            edge_pend_q <= edge_pend_d;
            intr_q      <= gie_q & any;
            if (wr) begin
                case (bus.AD)
                    REG_MASK: mask_q <= bus.DI[NUM_IRQ-1:0];
                    REG_MODE: mode_q <= bus.DI[NUM_IRQ-1:0];
                    REG_VEC:  gie_q  <= bus.DI[0];
                    default:  ;
                endcase
            end
        end
    end

    assign intr = intr_q;

    always_comb begin
        vec                        = '0;
        vec[VEC_ANY_BIT]           = any;
        vec[VEC_GIE_BIT]           = gie_q;
        vec[VEC_IDX_LSB +: 3]      = idx;
    end

    always_comb begin
        bus.DO = '0;
        unique case (bus.AD)
            REG_PEND: bus.DO = pend8;
            REG_MASK: bus.DO = mask8;
            REG_MODE: bus.DO = mode8;
            REG_VEC:  bus.DO = vec;
            default:  bus.DO = '0;
        endcase
    end

endmodule
